// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: one shared timebase, per-channel duty comparators,
// edge- or center-aligned counting, with period/duty/mode double-buffered to the period boundary.
module pwm_multi_gen #(
  parameter int WIDTH    = 13,
  parameter int CHANNELS = 4,
  localparam int AW      = $clog2(CHANNELS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                center_mode,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  output logic [CHANNELS-1:0] pwm,
  output logic [WIDTH-1:0]    counter,
  output logic                period_end
);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  dir_t                r_dir;
  dir_t                w_dir_nxt;
  logic [WIDTH-1:0]    r_counter;
  logic [WIDTH-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0]    r_period_sh;
  logic [WIDTH-1:0]    r_period_act;
  logic [WIDTH-1:0]    r_duty_sh  [CHANNELS];
  logic [WIDTH-1:0]    r_duty_act [CHANNELS];
  logic                r_mode_act;
  logic [CHANNELS-1:0] r_pwm;
  logic [CHANNELS-1:0] w_pwm_nxt;
  logic                r_period_end;
  logic                w_center;
  logic                w_u;

  // Center counting needs at least two steps up and down; otherwise fall back to edge mode.
  always_comb begin
    w_center = r_mode_act && (r_period_act >= WIDTH'(2));
    if (w_center) w_u = (r_dir == DIR_DOWN) && (r_counter == WIDTH'(1));
    else          w_u = (r_counter == r_period_act);
  end

  always_comb begin
    w_cnt_nxt = r_counter;
    w_dir_nxt = r_dir;
    if (!en || w_u) begin
      w_cnt_nxt = '0;
      w_dir_nxt = DIR_UP;
    end else if (r_dir == DIR_DOWN) begin
      w_cnt_nxt = r_counter - WIDTH'(1);
    end else if (w_center && (r_counter == r_period_act)) begin
      w_cnt_nxt = r_counter - WIDTH'(1);
      w_dir_nxt = DIR_DOWN;
    end else begin
      w_cnt_nxt = r_counter + WIDTH'(1);
    end
  end

  always_comb begin
    w_pwm_nxt = '0;
    for (int unsigned ch = 0; ch < CHANNELS; ch++)
      w_pwm_nxt[ch] = en && (r_counter < r_duty_act[ch]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period_sh <= '1;
      for (int unsigned ch = 0; ch < CHANNELS; ch++) r_duty_sh[ch] <= '0;
    end else if (wr_en) begin
      if (wr_addr == AW'(CHANNELS)) r_period_sh <= wr_data;
      for (int unsigned ch = 0; ch < CHANNELS; ch++)
        if (wr_addr == AW'(ch)) r_duty_sh[ch] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_counter    <= '0;
      r_dir        <= DIR_UP;
      r_pwm        <= '0;
      r_period_end <= 1'b0;
      r_period_act <= '1;
      r_mode_act   <= 1'b0;
      for (int unsigned ch = 0; ch < CHANNELS; ch++) r_duty_act[ch] <= '0;
    end else begin
      r_counter    <= w_cnt_nxt;
      r_dir        <= w_dir_nxt;
      r_pwm        <= w_pwm_nxt;
      r_period_end <= en && w_u;
      // While disabled the active set tracks the shadows so the first enabled period is current.
      if (!en || w_u) begin
        r_period_act <= r_period_sh;
        r_mode_act   <= center_mode;
        for (int unsigned ch = 0; ch < CHANNELS; ch++) r_duty_act[ch] <= r_duty_sh[ch];
      end
    end
  end

  assign pwm        = r_pwm;
  assign counter    = r_counter;
  assign period_end = r_period_end;

endmodule
